// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index type and pipeline controller state encoding.
package cpu_types_pkg;

    localparam int REGW = 5;

    typedef logic [REGW-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: the load in ID/EX writes a register that the
// instruction in IF/ID reads. Register 0 is hard-wired zero and never conflicts.
module hazard_detect #(
    parameter int REGW = 5
) (
    input  logic            ex_dren,
    input  logic [REGW-1:0] ex_rt,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    output logic            load_use
);

    assign load_use = ex_dren && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: decides capture/hold/bubble for the PC and the four
// pipeline latches each cycle, tracks outstanding data accesses and halt,
// and counts stall cycles (saturating) for performance debug.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNTW = 16,
    parameter int REGW = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_dren,
    input  logic            mem_dwen,
    input  logic            mem_halt,
    input  logic            mem_redirect,
    input  logic            ex_dren,
    input  logic [REGW-1:0] ex_rt,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    output logic            pc_en,
    output logic            imemREN,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            memwb_flush,
    output logic            halted,
    output logic [CNTW-1:0] stall_cnt
);

    ctrl_state_t     state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            load_use;
    logic            data_stall;

    hazard_detect #(.REGW(REGW)) u_hazard (
        .ex_dren  (ex_dren),
        .ex_rt    (ex_rt),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .load_use (load_use)
    );

    // A MEM-stage access that has not completed freezes everything upstream.
    assign data_stall = (mem_dren || mem_dwen) && !dhit;

    // Per-cycle latch actions in priority order, plus next FSM state.
    always_comb begin
        pc_en       = 1'b0;
        imemREN     = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        halted      = 1'b0;
        state_d     = state_q;
        if (!RST) begin
            if (state_q == HALTED) begin
                halted = 1'b1;
            end else begin
                imemREN = 1'b1;
                if (data_stall) begin
                    // Upstream holds; WB gets a bubble while the access is pending.
                    memwb_flush = 1'b1;
                    state_d     = DWAIT;
                end else if (mem_halt) begin
                    // Let HALT reach WB, then freeze for good.
                    memwb_en = 1'b1;
                    state_d  = HALTED;
                end else begin
                    state_d = RUN;
                    if (mem_redirect) begin
                        // Wrong-path instructions behind the branch are squashed.
                        pc_en       = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        memwb_en    = 1'b1;
                    end else if (load_use) begin
                        // Hold the consumer in ID, insert a bubble into EX.
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else if (!ihit) begin
                        // No instruction arrived: bubble into ID, rest advances.
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
            end
        end
    end

    // Stall counter: counts PC-frozen cycles outside HALTED, sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (!pc_en && (state_q != HALTED) && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    // State and counter registers; reset abandons any pending data wait.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver pushes hand-derived expected
// output vectors per cycle, a negedge monitor pops and compares.
module tb_pipeline_ctrl;

    logic       CLK, RST;
    logic       ihit, dhit, mem_dren, mem_dwen, mem_halt, mem_redirect, ex_dren;
    logic [4:0] ex_rt, id_rs, id_rt;

    logic        pc_en, imemREN, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
    logic [15:0] cnt16;
    logic        pc_en4, imemREN4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
    logic        ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4, halted4;
    logic [3:0]  cnt4;

    // {pc_en, imemREN, ifid_en, ifid_flush, idex_en, idex_flush,
    //  exmem_en, exmem_flush, memwb_en, memwb_flush, halted}
    localparam logic [10:0] RSTV   = 11'b00_00_00_00_00_0;
    localparam logic [10:0] NORMAL = 11'b11_10_10_10_10_0;
    localparam logic [10:0] DSTALL = 11'b01_00_00_00_01_0;
    localparam logic [10:0] MHALT  = 11'b01_00_00_00_10_0;
    localparam logic [10:0] REDIR  = 11'b11_01_01_01_10_0;
    localparam logic [10:0] LUSE   = 11'b01_00_01_10_10_0;
    localparam logic [10:0] FMISS  = 11'b01_01_10_10_10_0;
    localparam logic [10:0] HALTD  = 11'b00_00_00_00_00_1;

    typedef struct {
        logic [10:0] v;
        logic [15:0] c;
        logic [3:0]  c4;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_cnt = 0;
    logic [3:0]  exp_cnt4 = 0;

    pipeline_ctrl #(.CNTW(16), .REGW(5)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_halt(mem_halt),
        .mem_redirect(mem_redirect), .ex_dren(ex_dren), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .pc_en(pc_en), .imemREN(imemREN),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_flush(memwb_flush), .halted(halted), .stall_cnt(cnt16)
    );

    pipeline_ctrl #(.CNTW(4), .REGW(5)) dut4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_halt(mem_halt),
        .mem_redirect(mem_redirect), .ex_dren(ex_dren), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .pc_en(pc_en4), .imemREN(imemREN4),
        .ifid_en(ifid_en4), .idex_en(idex_en4), .exmem_en(exmem_en4), .memwb_en(memwb_en4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .exmem_flush(exmem_flush4),
        .memwb_flush(memwb_flush4), .halted(halted4), .stall_cnt(cnt4)
    );

    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    // Monitor: every negedge with a pending expectation, compare outputs.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [10:0] obs, obs4;
            e    = sb_q.pop_front();
            obs  = {pc_en, imemREN, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, exmem_flush, memwb_en, memwb_flush, halted};
            obs4 = {pc_en4, imemREN4, ifid_en4, ifid_flush4, idex_en4, idex_flush4,
                    exmem_en4, exmem_flush4, memwb_en4, memwb_flush4, halted4};
            checks = checks + 4;
            if (obs !== e.v) begin
                failures++;
                $display("FAIL ctrl_vec t=%0t actual=%b required=%b", $time, obs, e.v);
            end
            if (obs4 !== e.v) begin
                failures++;
                $display("FAIL ctrl_vec_cntw4 t=%0t actual=%b required=%b", $time, obs4, e.v);
            end
            if (cnt16 !== e.c) begin
                failures++;
                $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, cnt16, e.c);
            end
            if (cnt4 !== e.c4) begin
                failures++;
                $display("FAIL stall_cnt_cntw4 t=%0t actual=%0d required=%0d", $time, cnt4, e.c4);
            end
        end
    end

    task automatic clr_in();
        ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0; mem_halt = 1'b0;
        mem_redirect = 1'b0; ex_dren = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    endtask

    // Push the expectation for the current cycle, then advance one clock.
    task automatic cyc(input logic [10:0] e);
        sb_q.push_back('{e, exp_cnt, exp_cnt4});
        if (!RST && !e[10] && !e[0]) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (exp_cnt4 != 4'hF)    exp_cnt4 = exp_cnt4 + 4'd1;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        clr_in();
        cyc(RSTV);
        cyc(RSTV);
        RST = 1'b0;
        cyc(NORMAL);
        cyc(NORMAL);

        // Reset asserted while a load is outstanding
        mem_dren = 1'b1; dhit = 1'b0;
        cyc(DSTALL);
        RST = 1'b1; exp_cnt = 0; exp_cnt4 = 0;
        cyc(RSTV);
        RST = 1'b0; clr_in();
        cyc(NORMAL);

        // Load miss for three cycles, then completion
        mem_dren = 1'b1; dhit = 1'b0;
        cyc(DSTALL); cyc(DSTALL); cyc(DSTALL);
        dhit = 1'b1;
        cyc(NORMAL);
        clr_in(); mem_dwen = 1'b1; dhit = 1'b1;
        cyc(NORMAL);

        // Load-use hazards
        clr_in(); ex_dren = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd2;
        cyc(LUSE);
        ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
        cyc(LUSE);
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        cyc(NORMAL);
        ex_dren = 1'b0; ex_rt = 5'd5; id_rs = 5'd5;
        cyc(NORMAL);

        // Redirect beats fetch miss and load-use; load-use beats fetch miss
        clr_in(); mem_redirect = 1'b1; ihit = 1'b0;
        cyc(REDIR);
        ex_dren = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
        cyc(REDIR);
        mem_redirect = 1'b0;
        cyc(LUSE);

        // Data stall beats redirect; completion cycle then redirects
        clr_in(); mem_dren = 1'b1; mem_redirect = 1'b1; ihit = 1'b0;
        cyc(DSTALL);
        dhit = 1'b1;
        cyc(REDIR);
        // Data stall beats halt
        clr_in(); mem_dwen = 1'b1; mem_halt = 1'b1;
        cyc(DSTALL);

        // Long fetch miss saturates the narrow counter
        clr_in(); ihit = 1'b0;
        for (int i = 0; i < 20; i++) cyc(FMISS);

        // Halt, then random inputs must not disturb the halted state
        clr_in(); mem_halt = 1'b1;
        cyc(MHALT);
        for (int i = 0; i < 10; i++) begin
            {ihit, dhit, mem_dren, mem_dwen, mem_halt, mem_redirect, ex_dren} = 7'($urandom);
            ex_rt = 5'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
            cyc(HALTD);
        end

        repeat (2) @(negedge CLK);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Decides every cycle whether each latch captures, holds or takes a bubble, based on:
  - imem/dmem handshakes
  - load-use hazards
  - control-flow redirects resolved in MEM
  - halt
- Tracks outstanding data-memory accesses and the halted condition in a small FSM.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- CNTW, 16, width of stall_cnt.
- REGW, 5, register index width.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction memory returned valid data this cycle.
- dhit  in  1  data memory completed the MEM-stage access this cycle.
- mem_dren  in  1  EX/MEM latch holds a load.
- mem_dwen  in  1  EX/MEM latch holds a store.
- mem_halt  in  1  EX/MEM latch holds HALT.
- mem_redirect  in  1  branch taken / J / JAL / JR resolved in MEM.
- ex_dren  in  1  ID/EX latch holds a load.
- ex_rt  in  REGW  load destination in ID/EX.
- id_rs  in  REGW  rs of the instruction in IF/ID.
- id_rt  in  REGW  rt of the instruction in IF/ID.
- pc_en  out  1  PC update enable.
- imemREN  out  1  instruction fetch request.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch captures its input.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch loads a bubble.
- Latch action encoding:
  - en=1: capture.
  - flush=1: bubble.
  - en=0 and flush=0: hold.
  - en and flush are never both 1.
- halted  out  1  pipeline permanently halted.
- stall_cnt  out  CNTW  cycles with pc_en=0 outside HALTED, saturating.

Behaviour:
- Reset: one clock CLK; RST asynchronous, active-high.
  - While RST=1: all en/flush = 0, pc_en=0, imemREN=0, halted=0, stall_cnt=0, state=RUN.
  - RST asserted mid-access abandons the DWAIT state immediately.
- FSM states: RUN, DWAIT, HALTED. State is registered; all other outputs are combinational from state and inputs. Zero added latency.
- Transitions:
  - RUN -> DWAIT: (mem_dren|mem_dwen) & !dhit.
  - DWAIT -> RUN: dhit.
  - RUN -> HALTED: mem_halt with no pending data access.
  - HALTED is absorbing until RST.
- Output priority per cycle, highest first:
  1. HALTED: all en=0, all flush=0, pc_en=0, imemREN=0, halted=1.
  2. Data stall (mem op & !dhit, in RUN or DWAIT): pc/ifid/idex/exmem hold; memwb_flush=1. ihit is ignored in this case.
  3. mem_halt (no data stall): memwb_en=1 so WB sees HALT; pc/ifid/idex/exmem hold; next state HALTED.
  4. mem_redirect: pc_en=1; ifid_flush=idex_flush=exmem_flush=1; memwb_en=1. This applies even when ihit=0.
  5. Load-use: ex_dren & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
     - pc_en=0, ifid hold, idex_flush=1, exmem_en=memwb_en=1.
     - Register 0 never causes a hazard.
  6. Fetch miss (!ihit): pc_en=0, ifid_flush=1; idex/exmem/memwb en=1.
  7. Normal: pc_en=1, all en=1.
- Data access completes on dhit in DWAIT: that cycle behaves as rules 3–7 (full advance if nothing else applies).
- imemREN=1 in RUN and DWAIT.
- stall_cnt:
  - Increments on every clock where pc_en=0 and state!=HALTED.
  - Holds at 2^CNTW-1 once reached; no wrap.

Decomposition:
- cpu_types_pkg gains `ctrl_state_t` (RUN, DWAIT, HALTED) and reuses `regbits_t` for REGW-wide indices.
- One natural combinational sub-module: `hazard_detect` (load-use compare). All other logic lives in pipeline_ctrl.

Test Plan:
- Reset: RST=1 mid-DWAIT -> state RUN, all outputs 0, stall_cnt=0; release with ihit=1 -> next cycle pc_en=1, all en=1.
- Load miss: mem_dren=1, dhit=0 for 3 cycles, then dhit=1.
  - Response: DWAIT for 3 cycles with memwb_flush=1 and upstream holds; stall_cnt +3; release cycle gives all en=1.
- Load-use: ex_dren=1, ex_rt=5, id_rs=5 -> pc_en=0, idex_flush=1, ifid hold. Repeat with ex_rt=0 -> no stall.
- Redirect and miss: mem_redirect=1 with ihit=0 -> pc_en=1, ifid/idex/exmem flush=1, memwb_en=1.
- Halt: mem_halt=1, ihit=1 -> memwb_en=1 that cycle; next cycle halted=1, imemREN=0; stays after 10 cycles of random inputs.
- Saturation: CNTW=4, hold ihit=0 for 20 cycles -> stall_cnt=15 and holds.
